// File: rtl/register_file_pkg.sv
// Shared constants for the register file and the ALU datapath it feeds.
package register_file_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 2 ** ADDR_W;
  localparam int ZERO_REG  = 0;
endpackage

// File: rtl/register_file_decoder_5to32.sv
// One-hot write-enable decoder; index 0 never enabled so r0 stays hardwired zero.
module decoder_5to32
  import register_file_pkg::*;
#(
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[addr] = en;
    onehot[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/register_file.sv
// 2-read/1-write register file, r0 hardwired to zero, synchronous active-high reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  wr_en;

  decoder_5to32 #(.ADDR_W(ADDR_W)) u_decoder (
    .en     (reg_write),
    .addr   (write_reg),
    .onehot (wr_en)
  );

  // Reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en[i]) regs[i] <= write_data;
      end
    end
  end

  logic [DATA_W-1:0] stored1, stored2;
  logic              bypass1, bypass2;

  always_comb begin
    stored1 = (read_reg1 == ADDR_W'(ZERO_REG)) ? '0 : regs[read_reg1];
    stored2 = (read_reg2 == ADDR_W'(ZERO_REG)) ? '0 : regs[read_reg2];
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is off during reset so nothing leaks past the clear.
  always_comb begin
    bypass1 = reg_write && !reset && (write_reg != ADDR_W'(ZERO_REG)) && (read_reg1 == write_reg);
    bypass2 = reg_write && !reset && (write_reg != ADDR_W'(ZERO_REG)) && (read_reg2 == write_reg);
  end
`else
  always_comb begin
    bypass1 = 1'b0;
    bypass2 = 1'b0;
  end
`endif

  always_comb begin
    read_data1 = bypass1 ? write_data : stored1;
    read_data2 = bypass2 ? write_data : stored2;
  end

endmodule

// File: tb/tb_register_file.sv
// Randomized + directed bench for register_file against an array-based reference model.
module tb_register_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          reg_write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [AW-1:0] read_reg1, read_reg2;
  logic [DW-1:0] read_data1, read_data2;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [32];
  logic [DW-1:0] exp_q [$];

  register_file dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Value a read port should show during the current cycle.
  function automatic logic [DW-1:0] expect_read(input logic r, input logic we, input int wa,
                                                input logic [DW-1:0] wd, input int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!r && we && wa != 0 && wa == a) return wd;
`endif
    return model[a];
  endfunction

  task automatic cycle(input string tag, input logic r, input logic we, input int wa,
                       input logic [DW-1:0] wd, input int a1, input int a2);
    reset      = r;
    reg_write  = we;
    write_reg  = AW'(wa);
    write_data = wd;
    read_reg1  = AW'(a1);
    read_reg2  = AW'(a2);
    exp_q.push_back(expect_read(r, we, wa, wd, a1));
    exp_q.push_back(expect_read(r, we, wa, wd, a2));
    @(negedge clk);
    check({tag, ".rd1"}, read_data1, exp_q.pop_front());
    check({tag, ".rd2"}, read_data2, exp_q.pop_front());
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1;

    // Post-reset: all indices read zero on both ports.
    for (int i = 0; i < 32; i++) cycle("rst_read", 1'b0, 1'b0, 0, '0, i, 31 - i);

    // ALU operand example.
    cycle("w_r8", 1'b0, 1'b1, 8, 32'h0000000C, 0, 0);
    cycle("w_r9", 1'b0, 1'b1, 9, 32'h0000000A, 0, 0);
    cycle("rd_8_9", 1'b0, 1'b0, 0, '0, 8, 9);
    check("alu_and", read_data1 & read_data2, 32'h00000008);

    // r0 discards writes.
    cycle("w_r0", 1'b0, 1'b1, 0, 32'hFFFFFFFF, 0, 0);
    cycle("rd_r0", 1'b0, 1'b0, 0, '0, 0, 0);

    // Same-cycle read of the write target, then after the edge.
    cycle("wr_r5_same", 1'b0, 1'b1, 5, 32'h12345678, 5, 0);
    cycle("rd_r5_after", 1'b0, 1'b0, 0, '0, 5, 5);

    // Reset beats a simultaneous write and clears earlier data.
    cycle("rst_w_r3", 1'b1, 1'b1, 3, 32'hDEADBEEF, 3, 8);
    cycle("rd_3_8", 1'b0, 1'b0, 0, '0, 3, 8);

    // Disabled write leaves r31 alone; enabled write lands.
    cycle("w_r31_off", 1'b0, 1'b0, 31, 32'hFFFFFFFE, 31, 31);
    cycle("rd_r31_off", 1'b0, 1'b0, 0, '0, 31, 31);
    cycle("w_r31_on", 1'b0, 1'b1, 31, 32'hFFFFFFFE, 0, 0);
    cycle("rd_r31_on", 1'b0, 1'b0, 0, '0, 31, 31);

    // Random traffic with occasional resets and read-write collisions.
    for (int n = 0; n < 2000; n++) begin
      int wa, a1, a2;
      logic r, we;
      r  = ($urandom_range(0, 63) == 0);
      we = ($urandom_range(0, 3) != 0);
      wa = $urandom_range(0, 31);
      a1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      a2 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      cycle("rand", r, we, wa, $urandom, a1, a2);
    end

    // Final sweep of every register against the model.
    for (int i = 0; i < 32; i++) cycle("final", 1'b0, 1'b0, 0, '0, i, (i + 7) % 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
